// File: rtl/rv32_pipeline_pkg.sv
// Shared constants and types for the RV32IM pipeline stages.
package rv32_pipeline_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory READ/BUSYWAIT handshake between the fetch unit and memory.
interface instruction_fetch_unit_if;
  logic [31:0] IMEM_ADDRESS;
  logic        IMEM_READ;
  logic [31:0] IMEM_READDATA;
  logic        IMEM_BUSYWAIT;

  modport master (
    output IMEM_ADDRESS,
    output IMEM_READ,
    input  IMEM_READDATA,
    input  IMEM_BUSYWAIT
  );

  modport slave (
    input  IMEM_ADDRESS,
    input  IMEM_READ,
    output IMEM_READDATA,
    output IMEM_BUSYWAIT
  );
endinterface

// File: rtl/if_id_pipeline_reg.sv
// IF/ID pipeline register: bubble has priority over load; otherwise contents hold.
module if_id_pipeline_reg
  import rv32_pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               bubble_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [31:0]        pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        pc_plus4_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [31:0]        pc_d, pc_q;
  logic [31:0]        pc_plus4_d, pc_plus4_q;
  logic               valid_d, valid_q;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (bubble_i) begin
      // A bubble keeps the PC fields so downstream debug still sees the last address.
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_i + 32'd4;
      valid_d    = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, instruction-memory handshake, one-word stall buffer and branch redirect.
module instruction_fetch_unit
  import rv32_pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      BRANCH_TAKEN,
  input  logic [31:0]               BRANCH_TARGET,
  input  logic                      STALL,
  instruction_fetch_unit_if.master  imem,
  output logic [INSTR_W-1:0]        IFID_INSTRUCTION,
  output logic [31:0]               IFID_PC,
  output logic [31:0]               IFID_PC_PLUS4,
  output logic                      IFID_VALID
);

  fetch_state_e       state_d, state_q;
  logic [31:0]        pc_d, pc_q;
  logic [31:0]        discard_addr_d, discard_addr_q;
  logic [INSTR_W-1:0] buf_instr_d, buf_instr_q;
  logic [31:0]        buf_pc_d, buf_pc_q;

  logic               ifid_load;
  logic               ifid_bubble;
  logic [INSTR_W-1:0] ifid_instr;
  logic [31:0]        ifid_pc;
  logic               complete;
  logic [31:0]        target_aligned;

  assign target_aligned = BRANCH_TARGET & ~32'h3;
  assign complete       = imem.IMEM_READ && !imem.IMEM_BUSYWAIT;

  // Memory-side outputs depend on registered state only.
  always_comb begin
    imem.IMEM_READ    = (state_q != HOLD);
    imem.IMEM_ADDRESS = (state_q == DISCARD) ? discard_addr_q : pc_q;
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    discard_addr_d = discard_addr_q;
    buf_instr_d    = buf_instr_q;
    buf_pc_d       = buf_pc_q;
    ifid_load      = 1'b0;
    ifid_bubble    = 1'b0;
    ifid_instr     = imem.IMEM_READDATA;
    ifid_pc        = pc_q;

    unique case (state_q)
      FETCH: begin
        if (BRANCH_TAKEN) begin
          pc_d        = target_aligned;
          ifid_bubble = 1'b1;
          if (imem.IMEM_BUSYWAIT) begin
            // The old request is still outstanding; its address must stay on the bus.
            state_d        = DISCARD;
            discard_addr_d = pc_q;
          end
        end else if (!complete) begin
          ifid_bubble = !STALL;
        end else if (!STALL) begin
          ifid_load = 1'b1;
          pc_d      = pc_q + 32'd4;
        end else begin
          buf_instr_d = imem.IMEM_READDATA;
          buf_pc_d    = pc_q;
          pc_d        = pc_q + 32'd4;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (BRANCH_TAKEN) begin
          pc_d        = target_aligned;
          ifid_bubble = 1'b1;
          buf_instr_d = NOP_INSTR;
          buf_pc_d    = '0;
          state_d     = FETCH;
        end else if (!STALL) begin
          ifid_load  = 1'b1;
          ifid_instr = buf_instr_q;
          ifid_pc    = buf_pc_q;
          state_d    = FETCH;
        end
      end

      DISCARD: begin
        ifid_bubble = BRANCH_TAKEN || !STALL;
        if (BRANCH_TAKEN) begin
          pc_d = target_aligned;
        end else if (complete) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      discard_addr_q <= '0;
      // NOTE: the hold buffer is reset too, so an empty buffer never carries stale data.
      buf_instr_q    <= NOP_INSTR;
      buf_pc_q       <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      discard_addr_q <= discard_addr_d;
      buf_instr_q    <= buf_instr_d;
      buf_pc_q       <= buf_pc_d;
    end
  end

  if_id_pipeline_reg u_if_id (
    .clk        (CLK),
    .rst_n      (RESET),
    .load_i     (ifid_load),
    .bubble_i   (ifid_bubble),
    .instr_i    (ifid_instr),
    .pc_i       (ifid_pc),
    .instr_o    (IFID_INSTRUCTION),
    .pc_o       (IFID_PC),
    .pc_plus4_o (IFID_PC_PLUS4),
    .valid_o    (IFID_VALID)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table plus reset and wrap sequences.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;
  logic        busy = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] target = '0;

  logic [31:0] ifid_instr, ifid_pc, ifid_pc4;
  logic        ifid_valid;
  logic [31:0] w_instr, w_pc, w_pc4;
  logic        w_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  instruction_fetch_unit_if imem ();
  instruction_fetch_unit_if imem2 ();

  assign imem.IMEM_READDATA  = mem_word(imem.IMEM_ADDRESS);
  assign imem.IMEM_BUSYWAIT  = busy;
  assign imem2.IMEM_READDATA = mem_word(imem2.IMEM_ADDRESS);
  assign imem2.IMEM_BUSYWAIT = 1'b0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .CLK              (clk),
    .RESET            (rst_n),
    .BRANCH_TAKEN     (br),
    .BRANCH_TARGET    (target),
    .STALL            (stall),
    .imem             (imem.master),
    .IFID_INSTRUCTION (ifid_instr),
    .IFID_PC          (ifid_pc),
    .IFID_PC_PLUS4    (ifid_pc4),
    .IFID_VALID       (ifid_valid)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .CLK              (clk),
    .RESET            (rst2_n),
    .BRANCH_TAKEN     (1'b0),
    .BRANCH_TARGET    (32'h0),
    .STALL            (1'b0),
    .imem             (imem2.master),
    .IFID_INSTRUCTION (w_instr),
    .IFID_PC          (w_pc),
    .IFID_PC_PLUS4    (w_pc4),
    .IFID_VALID       (w_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        busy;
    logic        stall;
    logic        br;
    logic [31:0] target;
    logic        exp_read;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic b, input logic s, input logic r, input logic [31:0] t,
                              input logic rd, input logic [31:0] ad, input logic v,
                              input logic [31:0] pc);
    vec_t x;
    x.busy = b; x.stall = s; x.br = r; x.target = t;
    x.exp_read = rd; x.exp_addr = ad; x.exp_valid = v; x.exp_pc = pc;
    return x;
  endfunction

  initial begin
    //            busy stall br  target        read addr          valid pc
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h00,  1, 32'h00));  // streaming
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h04,  1, 32'h04));
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h08,  1, 32'h08));
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h0C,  1, 32'h0C));
    vq.push_back(mk(1, 0, 0, 32'h0,   1, 32'h10,  0, 32'h0C));  // 3 wait states
    vq.push_back(mk(1, 0, 0, 32'h0,   1, 32'h10,  0, 32'h0C));
    vq.push_back(mk(1, 0, 0, 32'h0,   1, 32'h10,  0, 32'h0C));
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h10,  1, 32'h10));
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h14,  1, 32'h14));
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h18,  1, 32'h18));
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h1C,  1, 32'h1C));
    vq.push_back(mk(0, 1, 0, 32'h0,   1, 32'h20,  1, 32'h1C));  // stall on complete -> HOLD
    vq.push_back(mk(0, 1, 0, 32'h0,   0, 32'h24,  1, 32'h1C));
    vq.push_back(mk(0, 0, 0, 32'h0,   0, 32'h24,  1, 32'h20));  // release: buffered word
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h24,  1, 32'h24));
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h28,  1, 32'h28));
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h2C,  1, 32'h2C));
    vq.push_back(mk(1, 0, 1, 32'h103, 1, 32'h30,  0, 32'h2C));  // branch mid-busy
    vq.push_back(mk(1, 0, 0, 32'h0,   1, 32'h30,  0, 32'h2C));
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h30,  0, 32'h2C));  // stale 0x30 dropped
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h100, 1, 32'h100));
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h104, 1, 32'h104));
    vq.push_back(mk(1, 1, 1, 32'h203, 1, 32'h108, 0, 32'h104)); // flush beats stall
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h108, 0, 32'h104));
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h200, 1, 32'h200));
    vq.push_back(mk(0, 0, 1, 32'h300, 1, 32'h204, 0, 32'h200)); // zero-wait redirect
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h300, 1, 32'h300));
    vq.push_back(mk(0, 1, 0, 32'h0,   1, 32'h304, 1, 32'h300)); // into HOLD
    vq.push_back(mk(0, 1, 1, 32'h400, 0, 32'h308, 0, 32'h300)); // branch in HOLD
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h400, 1, 32'h400));
    vq.push_back(mk(1, 1, 0, 32'h0,   1, 32'h404, 1, 32'h400)); // busy + stall holds
    vq.push_back(mk(0, 0, 0, 32'h0,   1, 32'h404, 1, 32'h404));

    // Reset state, sampled while reset is still asserted.
    #11;
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_instr", ifid_instr, NOP);
    check("rst_pc", ifid_pc, 32'd0);
    check("rst_pc4", ifid_pc4, 32'd0);
    check("rst_read", {31'd0, imem.IMEM_READ}, 32'd1);
    check("rst_addr", imem.IMEM_ADDRESS, 32'd0);
    #1 rst_n = 1'b1;

    foreach (vq[i]) begin
      busy = vq[i].busy; stall = vq[i].stall; br = vq[i].br; target = vq[i].target;
      check($sformatf("v%0d_read", i), {31'd0, imem.IMEM_READ}, {31'd0, vq[i].exp_read});
      check($sformatf("v%0d_addr", i), imem.IMEM_ADDRESS, vq[i].exp_addr);
      @(posedge clk); #1;
      check($sformatf("v%0d_valid", i), {31'd0, ifid_valid}, {31'd0, vq[i].exp_valid});
      check($sformatf("v%0d_pc", i), ifid_pc, vq[i].exp_pc);
      check($sformatf("v%0d_pc4", i), ifid_pc4, vq[i].exp_pc + 32'd4);
      check($sformatf("v%0d_instr", i), ifid_instr,
            vq[i].exp_valid ? mem_word(vq[i].exp_pc) : NOP);
    end
    busy = 1'b0; stall = 1'b0; br = 1'b0; target = '0;

    // Asynchronous reset while in HOLD.
    stall = 1'b1;
    @(posedge clk); #1;
    check("hold_read", {31'd0, imem.IMEM_READ}, 32'd0);
    rst_n = 1'b0;
    #2;
    check("arst_valid", {31'd0, ifid_valid}, 32'd0);
    check("arst_instr", ifid_instr, NOP);
    check("arst_pc", ifid_pc, 32'd0);
    check("arst_pc4", ifid_pc4, 32'd0);
    check("arst_read", {31'd0, imem.IMEM_READ}, 32'd1);
    check("arst_addr", imem.IMEM_ADDRESS, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; stall = 1'b0;
    check("rel_read", {31'd0, imem.IMEM_READ}, 32'd1);
    check("rel_addr", imem.IMEM_ADDRESS, 32'd0);
    @(posedge clk); #1;
    check("rel_valid", {31'd0, ifid_valid}, 32'd1);
    check("rel_pc", ifid_pc, 32'd0);
    check("rel_instr", ifid_instr, mem_word(32'd0));

    // PC wrap on the second instance.
    rst2_n = 1'b1;
    check("wrap_addr0", imem2.IMEM_ADDRESS, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("wrap_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", w_pc4, 32'h0);
    check("wrap_valid", {31'd0, w_valid}, 32'd1);
    check("wrap_instr", w_instr, mem_word(32'hFFFF_FFFC));
    check("wrap_addr1", imem2.IMEM_ADDRESS, 32'h0);
    @(posedge clk); #1;
    check("wrap_pc_next", w_pc, 32'h0);
    check("wrap_pc4_next", w_pc4, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction-fetch stage of the RV32IM pipeline. Holds the PC, issues reads to instruction memory over a READ/BUSYWAIT handshake, and loads the IF/ID pipeline register. The ID stage consumes its `IFID_INSTRUCTION` for decode and immediate sign extension. It absorbs memory wait states by inserting bubbles, buffers one fetched word while the pipeline is stalled, and redirects on taken branches and jumps.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset; bits [1:0] must be 0.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `BRANCH_TAKEN` in 1: redirect request from EX, one-cycle pulse.
- `BRANCH_TARGET` in 32: redirect address; bits [1:0] ignored and forced to 0.
- `STALL` in 1: hazard-unit freeze; IF/ID holds and PC does not advance past a buffered word.
- `IMEM_ADDRESS` out 32: fetch address.
- `IMEM_READ` out 1: read request.
- `IMEM_READDATA` in 32: instruction word; valid in any cycle where `IMEM_READ`=1 and `IMEM_BUSYWAIT`=0.
- `IMEM_BUSYWAIT` in 1: memory not ready.
- `IFID_INSTRUCTION` out 32: registered instruction.
- `IFID_PC` out 32: address of `IFID_INSTRUCTION`.
- `IFID_PC_PLUS4` out 32: `IFID_PC`+4, modulo 2^32.
- `IFID_VALID` out 1: 0 marks a bubble.

## Operation
- Bubble = {`INSTRUCTION`=32'h0000_0013 (NOP), `VALID`=0}. `IFID_PC` and `IFID_PC_PLUS4` keep their previous values on a bubble.
- Reset values:
  - PC=`RESET_PC`, state FETCH, hold buffer empty.
  - IF/ID = bubble, with `IFID_PC`=0 and `IFID_PC_PLUS4`=0.
- "Complete" means `IMEM_READ`=1 and `IMEM_BUSYWAIT`=0 in the same cycle.
- FETCH state: `IMEM_READ`=1, `IMEM_ADDRESS`=PC.
  - If `BRANCH_TAKEN`: PC←target and IF/ID←bubble. Next state is DISCARD (with DISCARD_ADDR←PC) when `IMEM_BUSYWAIT`=1, otherwise FETCH. Returned data is dropped.
  - Else if busy: IF/ID←bubble, or holds if `STALL`=1. Stay in FETCH.
  - Else (complete), `STALL`=0: IF/ID←{data, PC, PC+4, 1}, PC←PC+4, stay in FETCH.
  - Else (complete), `STALL`=1: hold buffer←{data, PC}, PC←PC+4, go to HOLD. IF/ID is unchanged.
- HOLD state: `IMEM_READ`=0, `IMEM_ADDRESS`=PC.
  - If `BRANCH_TAKEN`: PC←target, IF/ID←bubble, buffer cleared, go to FETCH.
  - Else if `STALL`=1: stay in HOLD.
  - Else: IF/ID←{buffer, 1}, go to FETCH.
- DISCARD state: `IMEM_READ`=1, `IMEM_ADDRESS`=DISCARD_ADDR, which stays stable while busy. IF/ID←bubble, or holds if `STALL`=1.
  - If `BRANCH_TAKEN`: PC←new target, stay in DISCARD.
  - On complete: data dropped, go to FETCH.
- `BRANCH_TAKEN` overrides `STALL` in every state: the flush wins.
- PC arithmetic is 32-bit unsigned and wraps: 0xFFFF_FFFC+4 = 0.
- `RESET` asserted mid-transaction returns to reset values immediately. Any in-flight memory response is ignored.

## Timing
- Zero-wait memory: one instruction per cycle. The word at PC appears in IF/ID on the next rising edge (1-cycle latency).
- N busy cycles insert N bubbles into IF/ID (when `STALL`=0).
- Taken-branch penalty from this stage, with zero-wait memory: the target instruction enters IF/ID one edge after the redirect edge. The redirect edge itself loads a bubble.
- `STALL` release from HOLD: the buffered word enters IF/ID on the release edge, and the next fetch starts the following cycle.
- `IMEM_ADDRESS` and `IMEM_READ` are decoded combinationally from registered state only, with no input-to-output paths.

## Structure
- Shared package `rv32_pipeline_pkg`:
  - NOP constant 32'h0000_0013.
  - Fetch-state enum {FETCH, HOLD, DISCARD}.
  - Instruction width 32.
- Sub-module `if_id_pipeline_reg`: the IF/ID register with load, hold and bubble controls. The ID/EX register reuses the same pattern.

## Test plan
- Reset: drive `RESET`=0 while in HOLD → all outputs at reset values, state FETCH. After release: `IMEM_READ`=1, `IMEM_ADDRESS`=`RESET_PC`.
- Streaming: zero-wait memory returning address-derived words, `RESET_PC`=0 → `IFID_PC` sequence 0x0, 0x4, 0x8, 0xC, with `VALID`=1 on every edge.
- Wait states: 3 busy cycles at 0x10 → three bubbles, then the instruction with `IFID_PC`=0x10 and `IFID_PC_PLUS4`=0x14.
- Stall on complete: `STALL`=1 when the word at 0x20 completes → HOLD, `IMEM_READ`=0, IF/ID unchanged. On release, IF/ID gets the 0x20 word, then the fetch at 0x24.
- Branch mid-busy: `BRANCH_TAKEN` with target 0x103 during a busy fetch at 0x30 → `IMEM_ADDRESS` stays 0x30 until complete, the 0x30 data never appears in IF/ID, and the next fetch is at 0x100. Repeat with `STALL`=1 asserted together with `BRANCH_TAKEN` → flush still taken.
- Wrap: `RESET_PC`=0xFFFF_FFFC → `IFID_PC_PLUS4`=0 and the next fetch address is 0x0.
